// File: rtl/video_pkg.sv
// Shared video-pipeline definitions: default pixel width and the
// ping-pong frame buffer read FSM state encoding.
package video_pkg;

    localparam int unsigned VIDEO_DATA_W = 8;

    // Read side: wait for a full bank, then stream it out.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

endpackage

// File: rtl/pingpong_frame_buffer_if.sv
// Write/read stream bundle for the ping-pong frame buffer.
//   master : pixel producer/consumer side (drives wr_valid, wr_data, rd_pause)
//   slave  : frame buffer side (drives ready, read data, done pulses, status)
interface pingpong_frame_buffer_if
    import video_pkg::*;
#(
    parameter int unsigned DATA_W = VIDEO_DATA_W,
    parameter int unsigned FCNT_W = 16
);

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              wr_frame_done;
    logic              rd_pause;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_frame_done;
    logic [1:0]        bank_full;
    logic [FCNT_W-1:0] frame_cnt;

    modport master (
        output wr_valid, wr_data, rd_pause,
        input  wr_ready, wr_frame_done, rd_valid, rd_data, rd_frame_done,
               bank_full, frame_cnt
    );

    modport slave (
        input  wr_valid, wr_data, rd_pause,
        output wr_ready, wr_frame_done, rd_valid, rd_data, rd_frame_done,
               bank_full, frame_cnt
    );

endinterface

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM holding both frame banks, addressed as {bank, addr}.
//   clk   : clock
//   rst   : synchronous clear of the read data register only (array untouched)
//   we    : write enable, waddr/wdata : write port
//   re    : read enable, raddr : read address; rdata updates 1 cycle later
//           and holds its value while re is low
module fb_bank_ram #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned WORDS  = 128,
    localparam int unsigned AW     = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Double-banked frame store: the writer fills one bank while the reader
// streams the other. Backpressure on write, pause on read, per-frame done
// pulses and a count of frames read out.
//   clk, rst (sync, active-high), clear (sync flush of banks and pointers)
//   bus.wr_valid/wr_data/wr_ready : pixel write handshake
//   bus.wr_frame_done             : pulse the cycle after a frame's last write
//   bus.rd_pause                  : downstream stall
//   bus.rd_valid/rd_data          : registered pixel output
//   bus.rd_frame_done             : pulse alongside a frame's last rd_valid
//   bus.bank_full                 : per-bank full flags
//   bus.frame_cnt                 : frames fully read, wraps
// The interface instance must be parameterised with the same DATA_W/FCNT_W.
module pingpong_frame_buffer
    import video_pkg::*;
#(
    parameter  int unsigned DATA_W = VIDEO_DATA_W,
    parameter  int unsigned DEPTH  = 64,
    parameter  int unsigned FCNT_W = 16,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    pingpong_frame_buffer_if.slave bus
);

    localparam int unsigned RAM_AW    = ADDR_W + 1;
    localparam int unsigned RAM_WORDS = 2 * (2 ** ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rd_state_e state_q, state_d;

    logic [1:0]        bank_full_q, bank_full_d;
    logic              wr_bank_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              wr_frame_done_q;
    logic              rd_bank_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_valid_q;
    logic              rd_frame_done_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic [DATA_W-1:0] ram_rdata;

    logic flush_c;
    logic wr_ready_c;
    logic wr_fire_c;
    logic wr_last_c;
    logic rd_issue_c;
    logic rd_last_c;

    // clear behaves like rst for state, but keeps the writer ready
    assign flush_c    = rst | clear;
    assign wr_ready_c = ~rst & ~bank_full_q[wr_bank_q];
    assign wr_fire_c  = bus.wr_valid & wr_ready_c;
    assign wr_last_c  = wr_fire_c & (wr_addr_q == LAST_ADDR);
    assign rd_last_c  = rd_issue_c & (rd_addr_q == LAST_ADDR);

    // Read FSM: state register
    always_ff @(posedge clk) begin
        if (flush_c) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM: next state and address issue strobe
    always_comb begin
        state_d    = state_q;
        rd_issue_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bank_full_q[rd_bank_q]) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (!bus.rd_pause) begin
                    rd_issue_c = 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Full flags: writer sets the bank it completes, reader clears the bank
    // it drains; the two never address the same bank in one cycle.
    always_comb begin
        bank_full_d = bank_full_q;
        if (wr_last_c) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
        if (rd_last_c) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (flush_c) begin
            bank_full_q <= '0;
        end else begin
            bank_full_q <= bank_full_d;
        end
    end

    // Write pointer and frame-done pulse
    always_ff @(posedge clk) begin
        if (flush_c) begin
            wr_bank_q       <= 1'b0;
            wr_addr_q       <= '0;
            wr_frame_done_q <= 1'b0;
        end else begin
            wr_frame_done_q <= wr_last_c;
            if (wr_fire_c) begin
                if (wr_last_c) begin
                    wr_addr_q <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_addr_q <= wr_addr_q + ADDR_W'(1);
                end
            end
        end
    end

    // Read pointer, valid/done strobes aligned with RAM output, frame count
    always_ff @(posedge clk) begin
        if (flush_c) begin
            rd_bank_q       <= 1'b0;
            rd_addr_q       <= '0;
            rd_valid_q      <= 1'b0;
            rd_frame_done_q <= 1'b0;
            frame_cnt_q     <= '0;
        end else begin
            rd_valid_q      <= rd_issue_c;
            rd_frame_done_q <= rd_last_c;
            if (rd_last_c) begin
                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            end
            if (rd_issue_c) begin
                if (rd_last_c) begin
                    rd_addr_q <= '0;
                    rd_bank_q <= ~rd_bank_q;
                end else begin
                    rd_addr_q <= rd_addr_q + ADDR_W'(1);
                end
            end
        end
    end

    fb_bank_ram #(
        .DATA_W (DATA_W),
        .WORDS  (RAM_WORDS)
    ) u_ram (
        .clk   (clk),
        .rst   (flush_c),
        .we    (wr_fire_c & ~clear),
        .waddr (RAM_AW'({wr_bank_q, wr_addr_q})),
        .wdata (bus.wr_data),
        .re    (rd_issue_c),
        .raddr (RAM_AW'({rd_bank_q, rd_addr_q})),
        .rdata (ram_rdata)
    );

    assign bus.wr_ready      = wr_ready_c;
    assign bus.wr_frame_done = wr_frame_done_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_data       = ram_rdata;
    assign bus.rd_frame_done = rd_frame_done_q;
    assign bus.bank_full     = bank_full_q;
    assign bus.frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
// Directed self-checking bench for pingpong_frame_buffer (DATA_W=8, DEPTH=4,
// FCNT_W=2 so the frame counter wrap is reachable quickly).
module tb_pingpong_frame_buffer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned FCNT_W = 2;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic clear = 1'b0;

    pingpong_frame_buffer_if #(.DATA_W(DATA_W), .FCNT_W(FCNT_W)) bus ();

    pingpong_frame_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FCNT_W (FCNT_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] cap  [$];
    logic [7:0] expq [$];
    int rd_done_n = 0;
    int wr_done_n = 0;

    // Collect read stream and done pulses away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rd_valid)      cap.push_back(bus.rd_data);
            if (bus.rd_frame_done) rd_done_n++;
            if (bus.wr_frame_done) wr_done_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_words(input logic [7:0] base, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 8'(i);
            w = 0;
            while (!bus.wr_ready && w < 100) begin
                tick();
                w++;
            end
            if (w >= 100) begin
                chk("wr_ready_timeout", 32'(bus.wr_ready), 32'd1);
                break;
            end
            tick();
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_rd_done(input int target);
        int w;
        w = 0;
        while (rd_done_n < target && w < 300) begin
            tick();
            w++;
        end
        chk("rd_done_count", 32'(rd_done_n), 32'(target));
        tick();
        tick();
    endtask

    task automatic push_frame(input logic [7:0] base);
        for (int i = 0; i < 4; i++) expq.push_back(base + 8'(i));
    endtask

    task automatic check_cap(input string tag);
        chk({tag, "_len"}, 32'(cap.size()), 32'(expq.size()));
        for (int i = 0; i < expq.size() && i < cap.size(); i++)
            chk(tag, 32'(cap[i]), 32'(expq[i]));
        cap.delete();
        expq.delete();
    endtask

    initial begin
        int d0;
        int w0;
        logic       seen;
        logic [7:0] last;

        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_pause = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
        chk("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
        chk("rst_rd_data",   32'(bus.rd_data),   32'd0);
        chk("rst_bank_full", 32'(bus.bank_full), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);

        // 1: one frame, exact latencies
        write_words(8'h10, 4);
        chk("t1_wr_frame_done", 32'(bus.wr_frame_done), 32'd1);
        chk("t1_bank_full",     32'(bus.bank_full),     32'b01);
        chk("t1_rd_valid_fill", 32'(bus.rd_valid),      32'd0);
        tick();
        chk("t1_wr_done_pulse", 32'(bus.wr_frame_done), 32'd0);
        chk("t1_rd_valid_turn", 32'(bus.rd_valid),      32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_rd_valid", 32'(bus.rd_valid),      32'd1);
            chk("t1_rd_data",  32'(bus.rd_data),       32'(8'h10 + 8'(i)));
            chk("t1_rd_done",  32'(bus.rd_frame_done), 32'(i == 3));
        end
        chk("t1_frame_cnt", 32'(bus.frame_cnt), 32'd1);
        chk("t1_bank_free", 32'(bus.bank_full), 32'd0);
        tick();
        chk("t1_rd_done_end",  32'(bus.rd_frame_done), 32'd0);
        chk("t1_rd_valid_end", 32'(bus.rd_valid),      32'd0);
        cap.delete();

        // 2: both banks fill under pause, writer stalls, release drains in order
        d0 = rd_done_n;
        bus.rd_pause = 1'b1;
        push_frame(8'h20);
        push_frame(8'h30);
        push_frame(8'h40);
        write_words(8'h20, 4);
        write_words(8'h30, 4);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h40;
        #1;
        chk("t2_wr_ready_stall", 32'(bus.wr_ready),  32'd0);
        chk("t2_bank_full",      32'(bus.bank_full), 32'b11);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_stall_ready", 32'(bus.wr_ready), 32'd0);
            chk("t2_paused_valid", 32'(bus.rd_valid), 32'd0);
        end
        bus.rd_pause = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_rd_data",  32'(bus.rd_data),  32'(8'h20 + 8'(i)));
            chk("t2_wr_ready", 32'(bus.wr_ready), 32'(i == 3));
        end
        chk("t2_bank_full_rel", 32'(bus.bank_full), 32'b01);
        write_words(8'h40, 4);
        wait_rd_done(d0 + 3);
        check_cap("t2_order");
        chk("t2_frame_cnt", 32'(bus.frame_cnt), 32'd0);

        // 3: pause every other cycle mid-frame
        d0 = rd_done_n;
        push_frame(8'h60);
        write_words(8'h60, 4);
        seen = 1'b0;
        last = '0;
        for (int i = 0; i < 12; i++) begin
            bus.rd_pause = i[0];
            tick();
            if (bus.rd_valid) begin
                seen = 1'b1;
                last = bus.rd_data;
            end else if (seen && cap.size() < 4) begin
                chk("t3_hold", 32'(bus.rd_data), 32'(last));
            end
        end
        bus.rd_pause = 1'b0;
        wait_rd_done(d0 + 1);
        check_cap("t3_order");
        chk("t3_frame_cnt", 32'(bus.frame_cnt), 32'd1);

        // 4: clear with a partial write and a read in flight
        d0 = rd_done_n;
        w0 = wr_done_n;
        write_words(8'h80, 4);
        write_words(8'h70, 2);
        chk("t4_pre_rd_valid", 32'(bus.rd_valid), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t4_bank_full",  32'(bus.bank_full),     32'd0);
        chk("t4_rd_valid",   32'(bus.rd_valid),      32'd0);
        chk("t4_rd_done",    32'(bus.rd_frame_done), 32'd0);
        chk("t4_wr_done",    32'(bus.wr_frame_done), 32'd0);
        chk("t4_wr_ready",   32'(bus.wr_ready),      32'd1);
        chk("t4_frame_cnt",  32'(bus.frame_cnt),     32'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_no_rd_done",    32'(rd_done_n),     32'(d0));
        chk("t4_wr_done_cnt",   32'(wr_done_n),     32'(w0 + 1));
        chk("t4_idle_rd_valid", 32'(bus.rd_valid),  32'd0);
        cap.delete();
        push_frame(8'h50);
        write_words(8'h50, 4);
        chk("t4_bank0_full", 32'(bus.bank_full), 32'b01);
        wait_rd_done(d0 + 1);
        check_cap("t4_order");

        // 5: rst together with clear mid-stream
        write_words(8'h90, 4);
        tick();
        tick();
        chk("t5_pre_rd_valid", 32'(bus.rd_valid), 32'd1);
        rst          = 1'b1;
        clear        = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hA0;
        #1;
        chk("t5_wr_ready_rst", 32'(bus.wr_ready), 32'd0);
        tick();
        chk("t5_wr_ready",  32'(bus.wr_ready),      32'd0);
        chk("t5_rd_valid",  32'(bus.rd_valid),      32'd0);
        chk("t5_rd_data",   32'(bus.rd_data),       32'd0);
        chk("t5_bank_full", 32'(bus.bank_full),     32'd0);
        chk("t5_frame_cnt", 32'(bus.frame_cnt),     32'd0);
        chk("t5_rd_done",   32'(bus.rd_frame_done), 32'd0);
        chk("t5_wr_done",   32'(bus.wr_frame_done), 32'd0);
        tick();
        chk("t5_no_write", 32'(bus.bank_full), 32'd0);
        rst          = 1'b0;
        clear        = 1'b0;
        bus.wr_valid = 1'b0;
        #1;
        chk("t5_wr_ready_after", 32'(bus.wr_ready), 32'd1);
        cap.delete();
        expq.delete();

        // 6: five frames wrap the 2-bit frame counter to 1
        d0 = rd_done_n;
        for (int f = 0; f < 5; f++) begin
            push_frame(8'hB0 + 8'(f * 16));
            write_words(8'hB0 + 8'(f * 16), 4);
        end
        wait_rd_done(d0 + 5);
        chk("t6_frame_cnt_wrap", 32'(bus.frame_cnt), 32'd1);
        check_cap("t6_order");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
